pwm_capture: RTL and testbench
==============================

# pwm_capture

Receive-side counterpart of the breathing-LED PWM generator. Samples an asynchronous PWM input, measures period and high time in sys_clk cycles for every complete cycle, and flags a stuck line (no edges within a timeout). Sits at a board input or loopback of the LED PWM output, feeding status logic and simulation checks of duty-cycle ramps.

## Interface
- CNT_W, 28, width of period and high_time counters and outputs.
- TIMEOUT, 14142, edge-free sys_clk cycles before the line is declared stuck. Two LED PWM periods of 7071. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W.
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- pwm_in  in  1  asynchronous PWM input.
- meas_valid  out  1  one-cycle pulse; period, high_time and level_stuck updated on the same edge.
- period  out  CNT_W  last measured period in cycles; 0 after a timeout.
- high_time  out  CNT_W  last measured high time in cycles; 0 after a timeout.
- level_stuck  out  1  high while the line is in timeout.
- stuck_level  out  1  sampled level at timeout, valid while level_stuck=1.
- duty_pct  out  7  floor(high_time*100/period); see Configuration.
- duty_valid  out  1  one-cycle pulse when duty_pct updates.
- Reset: sys_clk and sys_rst_n are the decided clock and reset; sys_rst_n is asynchronous, active-low.

## Operation
- Synchronizer: 2-FF chain on pwm_in producing s. A third register holds s_d. rise = s & ~s_d, fall = ~s & s_d.
- gap counter: cleared to 0 on any edge, otherwise increments and saturates at TIMEOUT-1.
- meas counter (CNT_W): loaded with 1 on rise, otherwise +1 while in HIGH or LOW. It saturates at all-ones, which is unreachable because the timeout fires first.
- FSM states:
  - IDLE: reset state. On rise, go to HIGH.
  - HIGH: on fall, latch hi_lat = meas counter and go to LOW.
  - LOW: on rise, set period = meas counter and high_time = hi_lat, pulse meas_valid, clear level_stuck, and go to HIGH (meas counter reloads 1).
  - STUCK: on rise, go to HIGH; on fall, go to IDLE. level_stuck stays 1 until the next meas_valid from LOW.
- Timeout: when the gap counter reaches TIMEOUT-1 with no edge in the same cycle, from IDLE, HIGH or LOW:
  - period and high_time are set to 0.
  - level_stuck is set to 1 and stuck_level = s.
  - meas_valid pulses once.
  - The FSM goes to STUCK. There is no repeated pulse while in STUCK.
- Simultaneous edge and timeout: the edge wins and the gap counter clears.
- Result for a steady input with H cycles high and L cycles low: period = H+L, high_time = H. The minimum legal period is H=L=1.
- Reset mid-measurement:
  - All outputs go to 0, FSM to IDLE, and counters, synchronizer and hi_lat clear.
  - The first rise after reset only starts a measurement. The first meas_valid comes at the second rise.

## Timing
- Synchronizer plus edge register latency is 3 edges. A rising pwm_in sampled at edge k produces a registered meas_valid/period update at edge k+3.
- meas_valid is never high on two consecutive cycles. The minimum spacing is 2 cycles (H=L=1).
- Reset values: meas_valid=0, period=0, high_time=0, level_stuck=0, stuck_level=0, duty_pct=0, duty_valid=0.

## Configuration
- Macro: PWM_DUTY_PCT_EN.
- Defined:
  - A restoring divider computes (high_time*100)/period with a (CNT_W+7)-bit numerator, one quotient bit per cycle.
  - Loading happens on the cycle after meas_valid. duty_pct and duty_valid update CNT_W+8 cycles after meas_valid.
  - A new meas_valid while the divider is busy aborts it and restarts with the new values, so no stale duty_valid is emitted.
  - On timeout, the divider is bypassed: duty_pct = 100 if stuck_level=1, else 0. duty_valid pulses 1 cycle after meas_valid.
- Not defined: no divider logic is built, and duty_pct and duty_valid are tied to 0.

## Test plan
- H=3000, L=4071 repeated 3 times:
  - period=7071 and high_time=3000 at each meas_valid, with the first pulse at the second rise.
  - With the macro, duty_pct=42 and duty_valid comes CNT_W+8 cycles later.
- pwm_in toggling every cycle (H=L=1): meas_valid every 2 cycles with period=2 and high_time=1. With the macro, the divider restarts continuously and duty_valid never asserts.
- pwm_in held high 20000 cycles after one full period:
  - A single meas_valid at gap=TIMEOUT-1 with period=0, high_time=0, level_stuck=1, stuck_level=1.
  - With the macro, duty_pct=100.
  - Then H=100, L=100 resumes: level_stuck clears at the first complete period, with period=200.
- Line held low from reset for 15000 cycles: timeout gives level_stuck=1, stuck_level=0 (duty_pct=0 with the macro), and no further meas_valid.
- sys_rst_n asserted mid-HIGH with H=500, L=500: outputs go to 0 immediately. After release, no meas_valid until the second rise, then period=1000 and high_time=500.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time capture with stuck-line detection
//
// Samples an asynchronous PWM input and measures the period and high time of
// every complete cycle in sys_clk cycles. A line without edges for TIMEOUT
// cycles is reported as stuck.
//
// Optional feature macro: PWM_DUTY_PCT_EN (adds a serial duty-percent divider).
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   pwm_in       in   asynchronous PWM input
//   meas_valid   out  one-cycle pulse; period/high_time/level_stuck updated
//   period       out  last measured period in cycles (0 after a timeout)
//   high_time    out  last measured high time in cycles (0 after a timeout)
//   level_stuck  out  line is in timeout
//   stuck_level  out  sampled line level at timeout
//   duty_pct     out  floor(high_time*100/period), 0 without PWM_DUTY_PCT_EN
//   duty_valid   out  one-cycle pulse when duty_pct updates
module pwm_capture #(
  parameter int CNT_W   = 28,
  parameter int TIMEOUT = 14142
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             level_stuck,
  output logic             stuck_level,
  output logic [6:0]       duty_pct,
  output logic             duty_valid
);

  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t           state_q, state_d;
  logic             sync1, s, s_d;
  logic             rise_q, fall_q;
  logic             edge_seen;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] meas_cnt;
  logic [CNT_W-1:0] hi_lat;
  logic             timeout;
  logic             do_meas, do_latch;

  // Two-flop synchronizer, delayed copy and a registered edge stage. s_d is
  // the level that lines up with rise_q/fall_q.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      s      <= sync1;
      s_d    <= s;
      rise_q <= s & ~s_d;
      fall_q <= ~s & s_d;
    end
  end

  assign edge_seen = rise_q | fall_q;

  // An edge in the same cycle as the timeout wins.
  assign timeout = (gap_cnt == GAP_MAX) && !edge_seen && (state_q != STUCK);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_cnt  <= '0;
      meas_cnt <= '0;
    end else begin
      if (edge_seen)
        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)
        gap_cnt <= gap_cnt + 1'b1;

      if (rise_q)
        meas_cnt <= CNT_W'(1);
      else if ((state_q == HIGH || state_q == LOW) && meas_cnt != '1)
        meas_cnt <= meas_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_meas  = 1'b0;
    do_latch = 1'b0;
    case (state_q)
      IDLE:  if (rise_q) state_d = HIGH;
      HIGH:  if (fall_q) begin
               do_latch = 1'b1;
               state_d  = LOW;
             end
      LOW:   if (rise_q) begin
               do_meas = 1'b1;
               state_d = HIGH;
             end
      STUCK: if (rise_q)      state_d = HIGH;
             else if (fall_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout)
      state_d = STUCK;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meas_valid  <= 1'b0;
      period      <= '0;
      high_time   <= '0;
      level_stuck <= 1'b0;
      stuck_level <= 1'b0;
      hi_lat      <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (do_latch)
        hi_lat <= meas_cnt;
      if (do_meas) begin
        period      <= meas_cnt;
        high_time   <= hi_lat;
        level_stuck <= 1'b0;
        meas_valid  <= 1'b1;
      end else if (timeout) begin
        period      <= '0;
        high_time   <= '0;
        level_stuck <= 1'b1;
        stuck_level <= s_d;
        meas_valid  <= 1'b1;
      end
    end
  end

`ifdef PWM_DUTY_PCT_EN
  localparam int NUM_W = CNT_W + 7;
  localparam int CW    = $clog2(NUM_W + 1);

  logic             div_busy;
  logic [CW-1:0]    div_cnt;
  logic [NUM_W-1:0] div_quo;
  logic [CNT_W-1:0] div_rem;
  logic [CNT_W-1:0] div_den;
  logic [CNT_W:0]   trial_in;
  logic [CNT_W:0]   trial_sub;
  logic             trial_ge;
  logic [NUM_W-1:0] new_quo;

  // div_quo starts as the numerator and shifts quotient bits in from the LSB.
  always_comb begin
    trial_in  = {div_rem, div_quo[NUM_W-1]};
    trial_ge  = (trial_in >= {1'b0, div_den});
    trial_sub = trial_in - {1'b0, div_den};
    new_quo   = {div_quo[NUM_W-2:0], trial_ge};
  end

  // A new measurement always reloads, aborting any division in flight.
  // A zero period only comes from a timeout, which bypasses the divider.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_busy   <= 1'b0;
      div_cnt    <= '0;
      div_quo    <= '0;
      div_rem    <= '0;
      div_den    <= '0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (meas_valid) begin
        if (period == '0) begin
          div_busy   <= 1'b0;
          duty_pct   <= stuck_level ? 7'd100 : 7'd0;
          duty_valid <= 1'b1;
        end else begin
          div_busy <= 1'b1;
          div_cnt  <= CW'(NUM_W);
          div_quo  <= NUM_W'(high_time) * NUM_W'(100);
          div_rem  <= '0;
          div_den  <= period;
        end
      end else if (div_busy) begin
        div_quo <= new_quo;
        div_rem <= trial_ge ? trial_sub[CNT_W-1:0] : trial_in[CNT_W-1:0];
        div_cnt <= div_cnt - 1'b1;
        if (div_cnt == CW'(1)) begin
          div_busy   <= 1'b0;
          duty_pct   <= new_quo[6:0];
          duty_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign duty_pct   = 7'd0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int CNT_W   = 28;
  localparam int TIMEOUT = 14142;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             pwm_in;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             level_stuck;
  logic             stuck_level;
  logic [6:0]       duty_pct;
  logic             duty_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
    logic             ls;
    logic             sl;
  } ev_t;

  ev_t        mq[$];
  int         dq_cyc[$];
  logic [6:0] dq_val[$];

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pwm_in      (pwm_in),
    .meas_valid  (meas_valid),
    .period      (period),
    .high_time   (high_time),
    .level_stuck (level_stuck),
    .stuck_level (stuck_level),
    .duty_pct    (duty_pct),
    .duty_valid  (duty_valid)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (meas_valid)
      mq.push_back('{cyc, period, high_time, level_stuck, stuck_level});
    if (duty_valid) begin
      dq_cyc.push_back(cyc);
      dq_val.push_back(duty_pct);
    end
  end

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mq.delete();
    dq_cyc.delete();
    dq_val.delete();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    repeat (3) @(negedge sys_clk);
    total_cnt++;
    if ({meas_valid, period, high_time, level_stuck, stuck_level, duty_pct, duty_valid} !== '0)
      $display("FAIL reset_outputs: got mv=%0b per=%0d hi=%0d ls=%0b sl=%0b duty=%0d dv=%0b, want all 0",
               meas_valid, period, high_time, level_stuck, stuck_level, duty_pct, duty_valid);
    else pass_cnt++;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_steady();
    int c0;
    do_reset();
    drive(0, 10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3000);
      drive(0, 4071);
    end
    c0 = cyc;
    drive(1, 100);
    drive(0, 100);
    total_cnt++;
    if (mq.size() != 3) $display("FAIL steady_count: got %0d events, want 3", mq.size());
    else pass_cnt++;
    foreach (mq[i]) begin
      total_cnt++;
      if (mq[i].per !== 7071 || mq[i].hi !== 3000 || mq[i].ls !== 1'b0)
        $display("FAIL steady_meas%0d: got per=%0d hi=%0d ls=%0b, want 7071/3000/0",
                 i, mq[i].per, mq[i].hi, mq[i].ls);
      else pass_cnt++;
    end
    if (mq.size() > 0) begin
      total_cnt++;
      if (mq[$].cyc - c0 != 4)
        $display("FAIL steady_latency: got %0d, want 4", mq[$].cyc - c0);
      else pass_cnt++;
    end
`ifdef PWM_DUTY_PCT_EN
    total_cnt++;
    if (dq_val.size() != 3) $display("FAIL steady_duty_count: got %0d, want 3", dq_val.size());
    else pass_cnt++;
    for (int i = 0; i < dq_val.size() && i < mq.size(); i++) begin
      total_cnt++;
      if (dq_val[i] !== 7'd42 || dq_cyc[i] - mq[i].cyc != CNT_W + 8)
        $display("FAIL steady_duty%0d: got duty=%0d lat=%0d, want 42/%0d",
                 i, dq_val[i], dq_cyc[i] - mq[i].cyc, CNT_W + 8);
      else pass_cnt++;
    end
`else
    total_cnt++;
    if (dq_val.size() != 0 || duty_pct !== 7'd0)
      $display("FAIL steady_duty_off: got %0d pulses duty=%0d, want 0/0", dq_val.size(), duty_pct);
    else pass_cnt++;
`endif
  endtask

  task automatic test_toggle();
    do_reset();
    drive(0, 10);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1);
      drive(0, 1);
    end
    drive(0, 10);
    total_cnt++;
    if (mq.size() != 19) $display("FAIL toggle_count: got %0d events, want 19", mq.size());
    else pass_cnt++;
    foreach (mq[i]) begin
      total_cnt++;
      if (mq[i].per !== 2 || mq[i].hi !== 1 || (i > 0 && mq[i].cyc - mq[i-1].cyc != 2))
        $display("FAIL toggle_meas%0d: got per=%0d hi=%0d gap=%0d, want 2/1/2",
                 i, mq[i].per, mq[i].hi, (i > 0) ? mq[i].cyc - mq[i-1].cyc : 2);
      else pass_cnt++;
    end
    total_cnt++;
    if (dq_val.size() != 0) $display("FAIL toggle_no_duty: got %0d duty pulses, want 0", dq_val.size());
    else pass_cnt++;
  endtask

  task automatic test_stuck_high();
    do_reset();
    drive(0, 10);
    drive(1, 100);
    drive(0, 100);
    drive(1, 20000);
    total_cnt++;
    if (mq.size() != 2) $display("FAIL stuckhi_count: got %0d events, want 2", mq.size());
    else pass_cnt++;
    if (mq.size() >= 2) begin
      total_cnt++;
      if (mq[0].per !== 200 || mq[0].hi !== 100)
        $display("FAIL stuckhi_first: got per=%0d hi=%0d, want 200/100", mq[0].per, mq[0].hi);
      else pass_cnt++;
      total_cnt++;
      if (mq[1].per !== 0 || mq[1].hi !== 0 || mq[1].ls !== 1'b1 || mq[1].sl !== 1'b1)
        $display("FAIL stuckhi_timeout: got per=%0d hi=%0d ls=%0b sl=%0b, want 0/0/1/1",
                 mq[1].per, mq[1].hi, mq[1].ls, mq[1].sl);
      else pass_cnt++;
      total_cnt++;
      if (mq[1].cyc - mq[0].cyc != TIMEOUT)
        $display("FAIL stuckhi_delay: got %0d, want %0d", mq[1].cyc - mq[0].cyc, TIMEOUT);
      else pass_cnt++;
`ifdef PWM_DUTY_PCT_EN
      total_cnt++;
      if (dq_val.size() != 2 || dq_val[0] !== 7'd50 || dq_val[1] !== 7'd100 || dq_cyc[1] - mq[1].cyc != 1)
        $display("FAIL stuckhi_duty: got %0d pulses last=%0d, want 2 pulses 50 then 100 one cycle after",
                 dq_val.size(), (dq_val.size() > 0) ? dq_val[$] : 7'd0);
      else pass_cnt++;
`endif
    end
    mq.delete();
    drive(0, 100);
    total_cnt++;
    if (mq.size() != 0 || level_stuck !== 1'b1)
      $display("FAIL stuckhi_hold: got %0d events ls=%0b, want 0/1", mq.size(), level_stuck);
    else pass_cnt++;
    drive(1, 100);
    drive(0, 100);
    drive(1, 100);
    drive(0, 10);
    total_cnt++;
    if (mq.size() != 1 || mq[0].per !== 200 || mq[0].hi !== 100 || mq[0].ls !== 1'b0)
      $display("FAIL stuckhi_resume: got %0d events per=%0d hi=%0d ls=%0b, want 1/200/100/0",
               mq.size(), (mq.size() > 0) ? mq[0].per : '0, (mq.size() > 0) ? mq[0].hi : '0,
               (mq.size() > 0) ? mq[0].ls : 1'b1);
    else pass_cnt++;
  endtask

  task automatic test_stuck_low();
    do_reset();
    drive(0, 15000);
    total_cnt++;
    if (mq.size() != 1) $display("FAIL stucklo_count: got %0d events, want 1", mq.size());
    else pass_cnt++;
    if (mq.size() > 0) begin
      total_cnt++;
      if (mq[0].per !== 0 || mq[0].hi !== 0 || mq[0].ls !== 1'b1 || mq[0].sl !== 1'b0)
        $display("FAIL stucklo_timeout: got per=%0d hi=%0d ls=%0b sl=%0b, want 0/0/1/0",
                 mq[0].per, mq[0].hi, mq[0].ls, mq[0].sl);
      else pass_cnt++;
    end
    total_cnt++;
    if (level_stuck !== 1'b1 || stuck_level !== 1'b0 || duty_pct !== 7'd0)
      $display("FAIL stucklo_outputs: got ls=%0b sl=%0b duty=%0d, want 1/0/0", level_stuck, stuck_level, duty_pct);
    else pass_cnt++;
`ifdef PWM_DUTY_PCT_EN
    total_cnt++;
    if (dq_val.size() != 1) $display("FAIL stucklo_duty: got %0d pulses, want 1", dq_val.size());
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 10);
    drive(1, 500);
    drive(0, 500);
    drive(1, 200);
    total_cnt++;
    if (period !== 1000) $display("FAIL rstmid_pre: got per=%0d, want 1000", period);
    else pass_cnt++;
    sys_rst_n = 1'b0;
    #1;
    total_cnt++;
    if (period !== 0 || high_time !== 0 || meas_valid !== 1'b0 || level_stuck !== 1'b0)
      $display("FAIL rstmid_async: got per=%0d hi=%0d mv=%0b ls=%0b, want 0", period, high_time, meas_valid, level_stuck);
    else pass_cnt++;
    pwm_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mq.delete();
    drive(0, 300);
    drive(1, 500);
    drive(0, 500);
    total_cnt++;
    if (mq.size() != 0) $display("FAIL rstmid_first_rise: got %0d events, want 0", mq.size());
    else pass_cnt++;
    drive(1, 500);
    drive(0, 10);
    total_cnt++;
    if (mq.size() != 1 || mq[0].per !== 1000 || mq[0].hi !== 500)
      $display("FAIL rstmid_second_rise: got %0d events per=%0d hi=%0d, want 1/1000/500",
               mq.size(), (mq.size() > 0) ? mq[0].per : '0, (mq.size() > 0) ? mq[0].hi : '0);
    else pass_cnt++;
  endtask

  initial begin
    pwm_in    = 1'b0;
    sys_rst_n = 1'b0;
    test_reset();
    test_steady();
    test_toggle();
    test_stuck_high();
    test_stuck_low();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
